// File: rtl/eth_tx_frame_fifo.sv
// Store-and-forward AXI-Stream frame buffer for the Ethernet TX path.
// Frames are released to the MAC only once fully buffered; bad or overflowing frames are rolled back.
module eth_tx_frame_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int ADDR_WIDTH = 9,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH:0]   fifo_level,
  output logic [CNT_WIDTH-1:0]  frames_sent,
  output logic [CNT_WIDTH-1:0]  frames_dropped,
  output logic                  overflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
  } beat_t;

  beat_t             r_mem [DEPTH];
  beat_t             r_out;
  beat_t             w_in;
  beat_t             w_rd_word;
  logic [PW-1:0]     r_wr_ptr, r_commit_ptr, r_rd_ptr;
  logic              r_drop, r_s_ready, r_m_tvalid, r_overflow;
  logic [CNT_WIDTH-1:0] r_frames_sent, r_frames_dropped;

  logic [PW-1:0] w_level;
  logic w_acc, w_full, w_wr, w_ovf_set, w_last;
  logic w_drop_ovf, w_drop_bad, w_commit;
  logic w_hs, w_load;

  // Full uses the pre-edge rd_ptr, so a same-cycle read never frees a slot early.
  always_comb begin
    w_in       = '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast};
    w_rd_word  = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    w_level    = r_wr_ptr - r_rd_ptr;
    w_full     = (w_level == DEPTH_P);
    w_acc      = s_axis_tvalid & r_s_ready;
    w_wr       = w_acc & ~r_drop & ~w_full;
    w_ovf_set  = w_acc & ~r_drop & w_full;
    w_last     = w_acc & s_axis_tlast;
    w_drop_ovf = w_last & (r_drop | w_full);
    w_drop_bad = w_last & ~w_drop_ovf & s_axis_tuser;
    w_commit   = w_last & ~w_drop_ovf & ~s_axis_tuser;
    w_hs       = r_m_tvalid & m_axis_tready;
    w_load     = (~r_m_tvalid | m_axis_tready) & (r_rd_ptr != r_commit_ptr);
  end

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= w_in;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_s_ready        <= 1'b0;
      r_wr_ptr         <= '0;
      r_commit_ptr     <= '0;
      r_drop           <= 1'b0;
      r_overflow       <= 1'b0;
      r_frames_dropped <= '0;
    end else begin
      r_s_ready  <= 1'b1;
      r_overflow <= w_drop_ovf;
      if (w_drop_ovf | w_drop_bad)
        r_wr_ptr <= r_commit_ptr;
      else if (w_wr)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_commit) r_commit_ptr <= r_wr_ptr + 1'b1;
      if (w_drop_ovf)
        r_drop <= 1'b0;
      else if (w_ovf_set)
        r_drop <= 1'b1;
      if ((w_drop_ovf | w_drop_bad) && (r_frames_dropped != '1))
        r_frames_dropped <= r_frames_dropped + 1'b1;
    end
  end

  // Single registered output stage; it doubles as the RAM read register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_out         <= '0;
      r_m_tvalid    <= 1'b0;
      r_rd_ptr      <= '0;
      r_frames_sent <= '0;
    end else begin
      if (w_load) begin
        r_out      <= w_rd_word;
        r_m_tvalid <= 1'b1;
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end else if (w_hs) begin
        r_m_tvalid <= 1'b0;
      end
      if (w_hs && r_out.last) r_frames_sent <= r_frames_sent + 1'b1;
    end
  end

  assign s_axis_tready  = r_s_ready;
  assign m_axis_tdata   = r_out.data;
  assign m_axis_tkeep   = r_out.keep;
  assign m_axis_tlast   = r_out.last;
  assign m_axis_tuser   = 1'b0;
  assign m_axis_tvalid  = r_m_tvalid;
  assign fifo_level     = w_level;
  assign frames_sent    = r_frames_sent;
  assign frames_dropped = r_frames_dropped;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// Directed + randomized bench for eth_tx_frame_fifo with a queue-based frame scoreboard.
module tb_eth_tx_frame_fifo;
  localparam int DW = 64, KW = 8, AW = 9, CW = 32, DEPTH = 512;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tlast = 1'b0, s_axis_tuser = 1'b0, s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast, m_axis_tuser, m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [AW:0]   fifo_level;
  logic [CW-1:0] frames_sent, frames_dropped;
  logic          overflow;

  eth_tx_frame_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .resetn(resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .fifo_level(fifo_level), .frames_sent(frames_sent), .frames_dropped(frames_dropped),
    .overflow(overflow)
  );

  initial forever #5 clock = ~clock;

  int    vectors = 0, miscompares = 0;
  int    in_beats = 0, out_beats = 0, ovf_pulses = 0;
  int    exp_sent = 0, exp_dropped = 0, exp_ovf = 0;
  bit    rand_rdy = 1'b0;
  logic  fixed_rdy = 1'b0;
  beat_t exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MAC ready driver: fixed level or 50% random, updated just after each edge.
  initial forever begin
    @(posedge clock); #1;
    m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
  end

  // Output monitor: scoreboard compare on handshakes, stability under stall.
  initial begin
    bit    stall;
    beat_t prev, got, e;
    stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        stall = 1'b0;
      end else begin
        got = '{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast};
        if (stall) begin
          chk("stall_valid", m_axis_tvalid, 1'b1);
          chk("stall_beat", got, prev);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          vectors++;
          assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL unexpected_beat: observed %0h expected none", got);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat", got, e);
          end
          chk("tuser_zero", m_axis_tuser, 1'b0);
          out_beats++;
        end
        stall = m_axis_tvalid && !m_axis_tready;
        prev  = got;
        if (overflow) ovf_pulses++;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Drive one frame at one beat per cycle (optional random idle gaps).
  task automatic send_frame(input int len, input bit bad, input bit gaps,
                            input bit use_lkeep, input logic [KW-1:0] lkeep, input bit pass);
    beat_t fr[$];
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = {$urandom(), $urandom()};
      b.k = 8'($urandom());
      b.l = (i == len - 1);
      if (b.l && use_lkeep) b.k = lkeep;
      fr.push_back(b);
    end
    if (pass) begin
      foreach (fr[i]) exp_q.push_back(fr[i]);
      in_beats += len;
      exp_sent++;
    end else begin
      exp_dropped++;
    end
    for (int i = 0; i < len; i++) begin
      if (gaps)
        while ($urandom_range(0, 3) == 0) begin
          s_axis_tvalid = 1'b0;
          @(posedge clock); #1;
        end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = fr[i].d;
      s_axis_tkeep  = fr[i].k;
      s_axis_tlast  = fr[i].l;
      s_axis_tuser  = fr[i].l ? bad : 1'($urandom());
      @(posedge clock); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(posedge clock);
      n++;
    end
    chk(tag, exp_q.size(), 0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_s_ready", s_axis_tready, 1'b0);
    chk("rst_m_valid", m_axis_tvalid, 1'b0);
    chk("rst_m_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, '0);
    chk("rst_level", fifo_level, 0);
    chk("rst_counters", {frames_sent, frames_dropped, overflow}, '0);
    @(posedge clock); #1;
    resetn = 1'b1;
    chk("rel_s_ready_low", s_axis_tready, 1'b0);
    @(posedge clock); #1;
    chk("rel_s_ready_high", s_axis_tready, 1'b1);

    // 8-beat frame: latency and back-to-back output
    fixed_rdy = 1'b1;
    @(posedge clock); #1;
    send_frame(8, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b1);
    @(negedge clock);
    chk("lat_not_yet", m_axis_tvalid, 1'b0);
    @(negedge clock);
    chk("lat_first", m_axis_tvalid, 1'b1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      chk("b2b_valid", m_axis_tvalid, 1'b1);
    end
    wait_drain("drain_t1");
    chk("t1_sent", frames_sent, exp_sent);

    // Bad frame then good 3-beat frame
    send_frame(5, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    send_frame(3, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    wait_drain("drain_t2");
    chk("t2_dropped", frames_dropped, exp_dropped);
    chk("t2_level", fifo_level, 0);
    chk("t2_sent", frames_sent, exp_sent);

    // 600-beat overflow frame, then 4-beat frame
    send_frame(600, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    exp_ovf++;
    send_frame(4, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    wait_drain("drain_t3");
    chk("t3_ovf_pulses", ovf_pulses, exp_ovf);
    chk("t3_dropped", frames_dropped, exp_dropped);
    chk("t3_sent", frames_sent, exp_sent);

    // Exactly DEPTH beats
    send_frame(DEPTH, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    wait_drain("drain_t4");
    chk("t4_sent", frames_sent, exp_sent);
    chk("t4_dropped", frames_dropped, exp_dropped);
    chk("t4_ovf_pulses", ovf_pulses, exp_ovf);

    // 200 random frames with random MAC ready
    rand_rdy = 1'b1;
    for (int f = 0; f < 200; f++) begin
      int len, n;
      len = $urandom_range(1, 190);
      n = 0;
      while ((in_beats - out_beats) + len + 2 > DEPTH && n < 5000) begin
        @(posedge clock); #1;
        n++;
      end
      send_frame(len, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    end
    wait_drain("drain_t5");
    rand_rdy = 1'b0;
    chk("t5_sent", frames_sent, exp_sent);
    chk("t5_dropped", frames_dropped, exp_dropped);
    chk("t5_level", fifo_level, 0);

    // Reset mid-frame on both sides
    fixed_rdy = 1'b0;
    @(posedge clock); #1;
    send_frame(20, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    fixed_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {$urandom(), $urandom()};
      s_axis_tkeep  = 8'hFF;
      s_axis_tlast  = 1'b0;
      @(posedge clock); #1;
    end
    #2;
    resetn = 1'b0;
    s_axis_tvalid = 1'b0;
    exp_q.delete();
    in_beats = 0; out_beats = 0; ovf_pulses = 0;
    exp_sent = 0; exp_dropped = 0; exp_ovf = 0;
    #1;
    chk("mid_rst_valid", m_axis_tvalid, 1'b0);
    chk("mid_rst_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, '0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_s_ready", s_axis_tready, 1'b0);
    chk("mid_rst_counters", {frames_sent, frames_dropped, overflow}, '0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    send_frame(2, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    wait_drain("drain_t6");
    repeat (20) @(posedge clock);
    #1;
    chk("t6_out_beats", out_beats, in_beats);
    chk("t6_sent", frames_sent, exp_sent);
    chk("t6_dropped", frames_dropped, exp_dropped);
    chk("t6_level", fifo_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
